// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: owner state, counter width, data request bundle.
package mem_arb_pkg;

    localparam int CNT_W      = 4;
    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        DM_RD = 2'd2,
        DM_WR = 2'd3
    } arb_owner_e;

    typedef struct packed {
        logic                    we;
        logic [PKG_DATA_W/8-1:0] be;
        logic [PKG_ADDR_W-1:0]   addr;
        logic [PKG_DATA_W-1:0]   wdata;
    } dm_req_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating fetch-starvation counter; registered, at_limit is combinational from the count.
// Clear has priority over increment; increment holds once LIMIT is reached.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    assign at_limit = (cnt >= CNT_W'(LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between fetch (IF) and data (DM); grants are combinational,
// read data returns one cycle after grant. DM wins unless IF has waited MAX_IF_WAIT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_IF_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_stall,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_owner_e       state_q;
    arb_owner_e       state_d;
    dm_req_t          dm_bundle;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             if_pri;
    logic             if_wait;

    assign dm_bundle.we    = dm_we;
    assign dm_bundle.be    = (PKG_DATA_W/8)'(dm_be);
    assign dm_bundle.addr  = PKG_ADDR_W'(dm_addr);
    assign dm_bundle.wdata = PKG_DATA_W'(dm_wdata);

    // Grants are gated by reset so every output is quiet while rst is low.
    assign if_pri   = if_req && starve_hit;
    assign if_gnt   = rst && if_req && (if_pri || !dm_req);
    assign dm_gnt   = rst && dm_req && !if_pri;
    assign if_stall = rst && if_req && !if_gnt;
    assign if_wait  = if_req && !if_gnt;

    mem_arb_starve_cnt #(
        .LIMIT (MAX_IF_WAIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (!if_wait),
        .inc      (if_wait),
        .cnt      (starve_cnt),
        .at_limit (starve_hit)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = '1;
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_bundle.we;
            mem_be    = BE_W'(dm_bundle.be);
            mem_addr  = ADDR_W'(dm_bundle.addr);
            mem_wdata = DATA_W'(dm_bundle.wdata);
        end
    end

    always_comb begin
        state_d = IDLE;
        if (if_gnt) begin
            state_d = IF_RD;
        end else if (dm_gnt) begin
            state_d = dm_bundle.we ? DM_WR : DM_RD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A read whose return cycle overlaps reset is dropped, not replayed.
    assign if_rvalid = rst && (state_q == IF_RD);
    assign dm_rvalid = rst && (state_q == DM_RD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_stall;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_dm_q[$];
    logic [31:0] sram[1024];

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_IF_WAIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_stall  (if_stall),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous-read SRAM with byte writes
    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
        sram[1] = 32'h1234_5678;
        mem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[11:2]];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a read return is presented.
    always @(negedge clk) begin
        if (if_rvalid) begin
            if (exp_if_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
            else chk("if_rdata", if_rdata, exp_if_q.pop_front());
        end else begin
            chk("if_rdata_idle", if_rdata, 32'h0);
        end
        if (dm_rvalid) begin
            if (exp_dm_q.size() == 0) chk("dm_rvalid_unexpected", 32'd1, 32'd0);
            else chk("dm_rdata", dm_rdata, exp_dm_q.pop_front());
        end else begin
            chk("dm_rdata_idle", dm_rdata, 32'h0);
        end
    end

    task automatic step(input string nm, input logic e_if, input logic e_dm,
                        input logic e_stall, input logic [31:0] e_addr);
        @(negedge clk);
        chk({nm, ".if_gnt"}, {31'h0, if_gnt}, {31'h0, e_if});
        chk({nm, ".dm_gnt"}, {31'h0, dm_gnt}, {31'h0, e_dm});
        chk({nm, ".if_stall"}, {31'h0, if_stall}, {31'h0, e_stall});
        chk({nm, ".mem_en"}, {31'h0, mem_en}, {31'h0, e_if | e_dm});
        chk({nm, ".mem_addr"}, mem_addr, (e_if | e_dm) ? e_addr : 32'h0);
        if (e_if) begin
            chk({nm, ".mem_we"}, {31'h0, mem_we}, 32'h0);
            chk({nm, ".mem_be"}, {28'h0, mem_be}, 32'hF);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_dm(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        dm_req = req; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wdata;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h4;
        set_dm(1'b1, 1'b1, 4'hF, 32'h200, 32'hFFFF_FFFF);

        // Reset holds every output low despite both requests
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.if_gnt", {31'h0, if_gnt}, 32'h0);
        chk("rst.dm_gnt", {31'h0, dm_gnt}, 32'h0);
        chk("rst.if_stall", {31'h0, if_stall}, 32'h0);
        chk("rst.mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst.mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst.mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.rvalids", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
        @(posedge clk);
        #1;

        // Release: arbitration live immediately, DM wins
        rst = 1'b1;
        set_dm(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        exp_dm_q.push_back(32'h0);
        step("release", 1'b0, 1'b1, 1'b1, 32'h200);
        if_req = 1'b0;
        set_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step("idle0", 1'b0, 1'b0, 1'b0, 32'h0);

        // IF only, three back-to-back fetches
        if_req = 1'b1;
        if_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            exp_if_q.push_back(32'h1234_5678);
            step("if_only", 1'b1, 1'b0, 1'b0, 32'h4);
        end
        if_req = 1'b0;
        step("idle1", 1'b0, 1'b0, 1'b0, 32'h0);

        // DM full write, read back, byte write, read back
        set_dm(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        step("dm_wr", 1'b0, 1'b1, 1'b0, 32'h100);
        set_dm(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        exp_dm_q.push_back(32'hDEAD_BEEF);
        step("dm_rd", 1'b0, 1'b1, 1'b0, 32'h100);
        set_dm(1'b1, 1'b1, 4'b0010, 32'h100, 32'h0000_AB00);
        step("dm_bwr", 1'b0, 1'b1, 1'b0, 32'h100);
        set_dm(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        exp_dm_q.push_back(32'hDEAD_ABEF);
        step("dm_brd", 1'b0, 1'b1, 1'b0, 32'h100);
        set_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step("idle2", 1'b0, 1'b0, 1'b0, 32'h0);

        // Starvation: four DM grants, IF on the fifth, then DM again
        if_req = 1'b1;
        set_dm(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_dm_q.push_back(32'hDEAD_ABEF);
            step("starve_dm", 1'b0, 1'b1, 1'b1, 32'h100);
        end
        exp_if_q.push_back(32'h1234_5678);
        step("starve_if", 1'b1, 1'b0, 1'b0, 32'h4);
        exp_dm_q.push_back(32'hDEAD_ABEF);
        step("starve_resume", 1'b0, 1'b1, 1'b1, 32'h100);
        if_req = 1'b0;
        set_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step("idle3", 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset during a DM read return with the starvation count at 3
        if_req = 1'b1;
        set_dm(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        exp_dm_q.push_back(32'hDEAD_ABEF);
        exp_dm_q.push_back(32'hDEAD_ABEF);
        for (int i = 0; i < 3; i++) step("pre_rst_dm", 1'b0, 1'b1, 1'b1, 32'h100);
        rst = 1'b0;
        if_req = 1'b0;
        set_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_mid_dm.dm_rvalid", {31'h0, dm_rvalid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_req = 1'b1;
        set_dm(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_dm_q.push_back(32'hDEAD_ABEF);
            step("post_rst_dm", 1'b0, 1'b1, 1'b1, 32'h100);
        end
        exp_if_q.push_back(32'h1234_5678);
        step("post_rst_if", 1'b1, 1'b0, 1'b0, 32'h4);

        // Reset the cycle after an IF grant: the fetch return is dropped
        set_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step("if_before_rst", 1'b1, 1'b0, 1'b0, 32'h4);
        rst = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_if.if_rvalid", {31'h0, if_rvalid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("after_rst_idle", 1'b0, 1'b0, 1'b0, 32'h0);
        step("after_rst_idle2", 1'b0, 1'b0, 1'b0, 32'h0);

        chk("if_queue_drained", exp_if_q.size(), 32'h0);
        chk("dm_queue_drained", exp_dm_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port unified memory arbiter for the mini-rv pipeline. It shares one synchronous-read SRAM between the fetch stage (instruction port, IF) and the memory stage (data port, DM). It routes read data back to the winner one cycle later and raises `if_stall`, which drives the fetch stage's `stall` input. Data accesses win by default; a starvation counter guarantees fetch progress.

## Interface
- `ADDR_W`, 32: address width, both ports and memory.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` wide.
- `MAX_IF_WAIT`, 4: consecutive denied IF cycles after which IF gets priority (range 1..15).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  ADDR_W  fetch byte address, word-aligned.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_stall`  out  1  `if_req & ~if_gnt`.
- `if_rvalid`  out  1  fetch read data valid.
- `if_rdata`  out  DATA_W  fetch read data.
- `dm_req`  in  1  data request.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_be`  in  DATA_W/8  write byte enables.
- `dm_addr`  in  ADDR_W  data byte address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_gnt`  out  1  data request accepted this cycle.
- `dm_rvalid`  out  1  data read data valid (reads only).
- `dm_rdata`  out  DATA_W  data read data.
- `mem_en`, `mem_we`  out  1  memory access strobe and write enable.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid 1 cycle after `mem_en & ~mem_we`.

## Operation
- At most one grant per cycle.
- Grants are combinational from the requests, the starvation count and reset.
- Priority:
  - If `if_req` and `starve_cnt >= MAX_IF_WAIT`, IF wins.
  - Otherwise DM wins if `dm_req`.
  - Otherwise IF wins if `if_req`.
- Memory outputs mux the winner's fields. An IF access forces `mem_we=0` and `mem_be` all ones. With no grant, `mem_en=0` and all other `mem_*` outputs are 0.
- Starvation counter `starve_cnt` (4 bits):
  - Cycle with `if_req & ~if_gnt`: increment, saturating at `MAX_IF_WAIT`.
  - Cycle with `if_gnt` or `~if_req`: clear to 0.
- Owner FSM records the last cycle's access for data routing. States are IDLE, IF_RD, DM_RD and DM_WR.
  - Next state is IF_RD on `if_gnt`, DM_RD on `dm_gnt & ~dm_we`, DM_WR on `dm_gnt & dm_we`, otherwise IDLE.
  - Any state can go to any state each cycle (back-to-back accesses, no bubble).
- Read return:
  - `if_rvalid` = (state == IF_RD).
  - `dm_rvalid` = (state == DM_RD).
  - Each `*_rdata` = `mem_rdata` when its rvalid is high, else 0.
  - DM_WR produces no rvalid.
- Requesters hold address/data stable while `req` is high and not granted. The arbiter does not latch requests.
- `if_addr[1:0] != 0` is out of contract. It is passed through unchanged.

## Timing
- Reset (`rst` low): state IDLE, `starve_cnt` 0, and every output forced to 0 (grants, stall, rvalids, rdata, `mem_*`), regardless of the requests.
- Grant to rvalid latency: exactly 1 cycle. Throughput: 1 access per cycle.
- Simultaneous `if_req` and `dm_req` with count below limit: DM granted, `if_stall`=1, count increments.
- With DM requesting every cycle, IF is granted on at most the (`MAX_IF_WAIT`+1)th consecutive request cycle.
- Reset asserted mid-access: the pending rvalid is dropped. It is not replayed after reset release.
- First cycle after reset release: arbitration is live; count starts at 0.

## Structure
- Package `mem_arb_pkg` holds:
  - owner state enum `arb_owner_e` (IDLE, IF_RD, DM_RD, DM_WR);
  - localparam for counter width;
  - request bundle struct `dm_req_t` (we, be, addr, wdata).
- One sub-module, `mem_arb_starve_cnt`: saturating counter with clear, increment and limit-reached output.
- The arbiter top holds the grant logic, the muxes and the owner FSM.

## Test plan
- Reset: hold `rst`=0 with `if_req`=`dm_req`=1 → all outputs 0. Release; the same cycle grants DM.
- IF only: `if_req`=1, `if_addr`=0x0000_0004 for 3 cycles → `if_gnt`=1 each cycle, `mem_addr`=0x4. `if_rvalid`=1 from the next cycle, and `if_rdata` equals the preloaded word.
- DM write then read: write 0xDEADBEEF to 0x100 with `be`=4'b1111, then read 0x100 → no rvalid on the write. `dm_rvalid`=1 one cycle after the read grant, `dm_rdata`=0xDEADBEEF.
- Byte write: `be`=4'b0010, `wdata`=0x0000_AB00 to 0x100, then read → 0xDEADABEF.
- Starvation: `dm_req` and `if_req` held high, `MAX_IF_WAIT`=4 → DM is granted 4 cycles, then IF on the 5th, then DM resumes. `if_stall` pattern is 1,1,1,1,0.
- Reset mid-read: assert `rst` low the cycle after an IF grant → no `if_rvalid`. After release, state is IDLE and the count is 0.
